// File: rtl/flu_wb_arbiter_if.sv
// Writeback arbiter bus: N unit result channels in, P scoreboard write ports out.
// EXC_W stands in for $bits(exception_t); TID_W for TRANS_ID_BITS.
interface flu_wb_arbiter_if #(
    parameter int unsigned NUM_UNITS    = 4,
    parameter int unsigned NUM_WB_PORTS = 2,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned TID_W        = 3,
    parameter int unsigned EXC_W        = 8
);
    localparam int unsigned UNIT_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]              unit_valid_i;
    logic [NUM_UNITS-1:0]              unit_ready_o;
    logic [NUM_UNITS*DATA_W-1:0]       unit_result_i;
    logic [NUM_UNITS*TID_W-1:0]        unit_trans_id_i;
    logic [NUM_UNITS*EXC_W-1:0]        unit_exception_i;
    logic [NUM_WB_PORTS-1:0]           wb_valid_o;
    logic [NUM_WB_PORTS*DATA_W-1:0]    wb_result_o;
    logic [NUM_WB_PORTS*TID_W-1:0]     wb_trans_id_o;
    logic [NUM_WB_PORTS*EXC_W-1:0]     wb_exception_o;
    logic [NUM_WB_PORTS*UNIT_W-1:0]    wb_unit_o;

    modport master (
        output unit_valid_i, unit_result_i, unit_trans_id_i, unit_exception_i,
        input  unit_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_exception_o, wb_unit_o
    );

    modport slave (
        input  unit_valid_i, unit_result_i, unit_trans_id_i, unit_exception_i,
        output unit_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_exception_o, wb_unit_o
    );
endinterface

// File: rtl/flu_wb_arbiter.sv
// Multi-port round-robin writeback arbiter: per-unit FIFOs, up to P retirements per cycle.
// Optional FLU_WB_BYPASS_EN forwards a result from an empty FIFO in the same cycle.
module flu_wb_arbiter #(
    parameter int unsigned NUM_UNITS    = 4,
    parameter int unsigned NUM_WB_PORTS = 2,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned TID_W        = 3,
    parameter int unsigned EXC_W        = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    flu_wb_arbiter_if.slave bus,
    output logic [31:0]     conflict_cnt_o
);
    localparam int unsigned UW = $clog2(NUM_UNITS);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    if (NUM_UNITS < 2) begin : g_err_units
        $error("flu_wb_arbiter: NUM_UNITS must be >= 2");
    end
    if (NUM_WB_PORTS < 1 || NUM_WB_PORTS > NUM_UNITS) begin : g_err_ports
        $error("flu_wb_arbiter: NUM_WB_PORTS must be in 1..NUM_UNITS");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth
        $error("flu_wb_arbiter: DEPTH must be a power of 2, >= 2");
    end

    logic [DATA_W-1:0] r_data [NUM_UNITS][DEPTH];
    logic [TID_W-1:0]  r_tid  [NUM_UNITS][DEPTH];
    logic [EXC_W-1:0]  r_exc  [NUM_UNITS][DEPTH];
    logic [PW-1:0]     r_wptr [NUM_UNITS];
    logic [PW-1:0]     r_rptr [NUM_UNITS];
    logic [UW-1:0]     r_rr;
    logic [31:0]       r_conflict_cnt;

    logic [NUM_UNITS-1:0]    w_empty, w_full, w_cand, w_fwd, w_gnt, w_push, w_pop;
    logic [DATA_W-1:0]       w_head_data [NUM_UNITS];
    logic [TID_W-1:0]        w_head_tid  [NUM_UNITS];
    logic [EXC_W-1:0]        w_head_exc  [NUM_UNITS];
    logic [NUM_WB_PORTS-1:0] w_port_vld;
    logic [UW-1:0]           w_port_unit [NUM_WB_PORTS];
    logic [UW-1:0]           w_rr_next;
    logic                    w_conflict;
    logic                    w_xfer_en;

    assign w_xfer_en        = !rst_i && !flush_i;
    assign bus.unit_ready_o = rst_i ? '0 : ~w_full;
    assign conflict_cnt_o   = r_conflict_cnt;

    always_comb begin : fifo_head
        w_empty = '0;
        w_full  = '0;
        w_cand  = '0;
        w_fwd   = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            w_empty[i] = (r_wptr[i] == r_rptr[i]);
            w_full[i]  = (r_wptr[i][AW] != r_rptr[i][AW]) &&
                         (r_wptr[i][AW-1:0] == r_rptr[i][AW-1:0]);
            w_head_data[i] = r_data[i][r_rptr[i][AW-1:0]];
            w_head_tid[i]  = r_tid[i][r_rptr[i][AW-1:0]];
            w_head_exc[i]  = r_exc[i][r_rptr[i][AW-1:0]];
`ifdef FLU_WB_BYPASS_EN
            w_fwd[i] = w_empty[i] && bus.unit_valid_i[i];
            if (w_empty[i]) begin
                w_head_data[i] = bus.unit_result_i[i*DATA_W +: DATA_W];
                w_head_tid[i]  = bus.unit_trans_id_i[i*TID_W +: TID_W];
                w_head_exc[i]  = bus.unit_exception_i[i*EXC_W +: EXC_W];
            end
`endif
            w_cand[i] = !w_empty[i] || w_fwd[i];
        end
    end

    // Scan from r_rr with wrap; the k-th candidate found drives port k.
    always_comb begin : grant
        int unsigned g;
        int unsigned ncand;
        int unsigned idx;
        g          = 0;
        ncand      = 0;
        idx        = 0;
        w_gnt      = '0;
        w_port_vld = '0;
        w_rr_next  = r_rr;
        for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
            w_port_unit[p] = '0;
        end
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            idx = (32'(r_rr) + k) % NUM_UNITS;
            if (w_cand[idx]) begin
                ncand = ncand + 1;
                if (g < NUM_WB_PORTS) begin
                    w_gnt[idx]     = 1'b1;
                    w_port_vld[g]  = 1'b1;
                    w_port_unit[g] = UW'(idx);
                    w_rr_next      = UW'((idx + 1) % NUM_UNITS);
                    g = g + 1;
                end
            end
        end
        w_conflict = (ncand > NUM_WB_PORTS);
    end

    always_comb begin : wb_drive
        bus.wb_valid_o     = '0;
        bus.wb_result_o    = '0;
        bus.wb_trans_id_o  = '0;
        bus.wb_exception_o = '0;
        bus.wb_unit_o      = '0;
        if (w_xfer_en) begin
            for (int unsigned p = 0; p < NUM_WB_PORTS; p++) begin
                if (w_port_vld[p]) begin
                    bus.wb_valid_o[p]                       = 1'b1;
                    bus.wb_result_o[p*DATA_W +: DATA_W]     = w_head_data[w_port_unit[p]];
                    bus.wb_trans_id_o[p*TID_W +: TID_W]     = w_head_tid[w_port_unit[p]];
                    bus.wb_exception_o[p*EXC_W +: EXC_W]    = w_head_exc[w_port_unit[p]];
                    bus.wb_unit_o[p*UW +: UW]               = w_port_unit[p];
                end
            end
        end
    end

    // A forwarded result that wins is consumed directly and never written.
    always_comb begin : push_pop
        w_push = '0;
        w_pop  = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            w_pop[i]  = w_xfer_en && w_gnt[i] && !w_empty[i];
            w_push[i] = w_xfer_en && bus.unit_valid_i[i] && !w_full[i] &&
                        !(w_gnt[i] && w_fwd[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
            r_rr           <= '0;
            r_conflict_cnt <= '0;
        end else if (flush_i) begin
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
            end
            if (|w_gnt) r_rr <= w_rr_next;
            if (w_conflict && r_conflict_cnt != '1) r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (w_push[i]) begin
                r_data[i][r_wptr[i][AW-1:0]] <= bus.unit_result_i[i*DATA_W +: DATA_W];
                r_tid[i][r_wptr[i][AW-1:0]]  <= bus.unit_trans_id_i[i*TID_W +: TID_W];
                r_exc[i][r_wptr[i][AW-1:0]]  <= bus.unit_exception_i[i*EXC_W +: EXC_W];
            end
        end
    end
endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Directed bench for flu_wb_arbiter (N=4, P=2, DEPTH=2); bypass build selected by FLU_WB_BYPASS_EN.
module tb_flu_wb_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned P  = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned TW = 3;
    localparam int unsigned EW = 8;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic [31:0] conflict_cnt;
    int unsigned n_total;
    int unsigned n_pass;

    flu_wb_arbiter_if #(
        .NUM_UNITS(N), .NUM_WB_PORTS(P), .DATA_W(DW), .TID_W(TW), .EXC_W(EW)
    ) bus ();

    flu_wb_arbiter #(
        .NUM_UNITS(N), .NUM_WB_PORTS(P), .DEPTH(2), .DATA_W(DW), .TID_W(TW), .EXC_W(EW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .bus            (bus),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        bus.unit_valid_i     = '0;
        bus.unit_result_i    = '0;
        bus.unit_trans_id_i  = '0;
        bus.unit_exception_i = '0;
    endtask

    task automatic drive(input int unsigned u, input logic [63:0] d, input logic [2:0] t,
                         input logic [7:0] e);
        bus.unit_valid_i[u]           = 1'b1;
        bus.unit_result_i[u*DW +: DW] = d;
        bus.unit_trans_id_i[u*TW +: TW]  = t;
        bus.unit_exception_i[u*EW +: EW] = e;
    endtask

    function automatic logic [63:0] res(input int unsigned p);
        return bus.wb_result_o[p*DW +: DW];
    endfunction

    function automatic logic [63:0] unit(input int unsigned p);
        return 64'(bus.wb_unit_o[p*2 +: 2]);
    endfunction

    function automatic logic [63:0] vld();
        return 64'(bus.wb_valid_o);
    endfunction

    function automatic logic [63:0] rdy();
        return 64'(bus.unit_ready_o);
    endfunction

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_i   = 1'b1;
        flush_i = 1'b0;
        idle_all();
        #3;
        check("rst_ready_gated", rdy(), 64'h0);
        check("rst_wb_gated", vld(), 64'h0);
        step();
        step();
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", rdy(), 64'hF);
        check("post_rst_valid", vld(), 64'h0);
        check("post_rst_cnt", 64'(conflict_cnt), 64'h0);

`ifdef FLU_WB_BYPASS_EN
        drive(0, 64'h55, 3'd1, 8'h0);
        #1;
        check("byp_valid", vld(), 64'h1);
        check("byp_res", res(0), 64'h55);
        check("byp_unit", unit(0), 64'h0);
        step();
        idle_all();
        #1;
        check("byp_not_stored", vld(), 64'h0);
        check("byp_ready", rdy(), 64'hF);
        // rr is now 1: units 1,2 forward, unit 0 loses and is stored
        drive(0, 64'h60, 3'd0, 8'h0);
        drive(1, 64'h61, 3'd1, 8'h0);
        drive(2, 64'h62, 3'd2, 8'h0);
        #1;
        check("byp3_valid", vld(), 64'h3);
        check("byp3_p0_unit", unit(0), 64'h1);
        check("byp3_p1_res", res(1), 64'h62);
        step();
        idle_all();
        #1;
        check("byp3_loser_valid", vld(), 64'h1);
        check("byp3_loser_res", res(0), 64'h60);
        check("byp3_loser_unit", unit(0), 64'h0);
`else
        // single push: one cycle latency, rr moves to 3
        drive(2, 64'hAB, 3'd3, 8'h5);
        #1;
        check("t1_c0_valid", vld(), 64'h0);
        step();
        idle_all();
        #1;
        check("t1_valid", vld(), 64'h1);
        check("t1_res", res(0), 64'hAB);
        check("t1_tid", 64'(bus.wb_trans_id_o[0 +: TW]), 64'h3);
        check("t1_exc", 64'(bus.wb_exception_o[0 +: EW]), 64'h5);
        check("t1_unit", unit(0), 64'h2);
        check("t1_p1_res_zero", res(1), 64'h0);
        step();
        check("t1_drained", vld(), 64'h0);

        // all four push; scan starts at rr=3
        for (int unsigned u = 0; u < N; u++) drive(u, 64'h100 + 64'(u), 3'(u), 8'h0);
        #1;
        check("t2_c0_valid", vld(), 64'h0);
        step();
        idle_all();
        #1;
        check("t2_c1_valid", vld(), 64'h3);
        check("t2_c1_p0_unit", unit(0), 64'h3);
        check("t2_c1_p1_unit", unit(1), 64'h0);
        check("t2_c1_p0_res", res(0), 64'h103);
        check("t2_c1_p1_res", res(1), 64'h100);
        step();
        check("t2_c2_p0_unit", unit(0), 64'h1);
        check("t2_c2_p1_unit", unit(1), 64'h2);
        check("t2_c2_p1_res", res(1), 64'h102);
        step();
        check("t2_c3_valid", vld(), 64'h0);
        check("t2_cnt", 64'(conflict_cnt), 64'h1);

        // unit 1 pushes D1..D3 while units 0 and 3 keep winning
        drive(0, 64'hA0, 3'd0, 8'h0);
        drive(3, 64'hB0, 3'd0, 8'h0);
        drive(1, 64'hD1, 3'd1, 8'h0);
        step();
        drive(0, 64'hA1, 3'd0, 8'h0);
        drive(3, 64'hB1, 3'd0, 8'h0);
        drive(1, 64'hD2, 3'd2, 8'h0);
        #1;
        check("t3_c1_p0_unit", unit(0), 64'h3);
        check("t3_c1_p1_res", res(1), 64'hA0);
        step();
        drive(0, 64'hA2, 3'd0, 8'h0);
        drive(3, 64'hB2, 3'd0, 8'h0);
        drive(1, 64'hD3, 3'd3, 8'h0);
        #1;
        check("t3_c2_ready", rdy(), 64'hD);
        check("t3_c2_p0_res", res(0), 64'hD1);
        check("t3_c2_p1_res", res(1), 64'hB1);
        step();
        drive(0, 64'hA3, 3'd0, 8'h0);
        drive(3, 64'hB3, 3'd0, 8'h0);
        #1;
        check("t3_c3_ready", rdy(), 64'hE);
        check("t3_c3_p0_res", res(0), 64'hA1);
        check("t3_c3_p1_res", res(1), 64'hD2);
        step();
        idle_all();
        #1;
        check("t3_c4_p0_res", res(0), 64'hB2);
        check("t3_c4_p1_res", res(1), 64'hA2);
        step();
        check("t3_c5_p0_res", res(0), 64'hD3);
        check("t3_c5_p1_res", res(1), 64'hB3);
        step();
        check("t3_c6_valid", vld(), 64'h0);
        check("t3_cnt", 64'(conflict_cnt), 64'h5);

        // five entries buffered, then flush with a push present
        for (int unsigned u = 0; u < N; u++) drive(u, 64'h200 + 64'(u), 3'(u), 8'h0);
        step();
        idle_all();
        for (int unsigned u = 0; u < 3; u++) drive(u, 64'h210 + 64'(u), 3'(u), 8'h0);
        #1;
        check("t4_c1_p1_unit", unit(1), 64'h1);
        step();
        idle_all();
        flush_i = 1'b1;
        drive(3, 64'h2FF, 3'd7, 8'h0);
        #1;
        check("t4_flush_valid", vld(), 64'h0);
        step();
        flush_i = 1'b0;
        idle_all();
        #1;
        check("t4_after_valid", vld(), 64'h0);
        check("t4_after_ready", rdy(), 64'hF);
        check("t4_after_cnt", 64'(conflict_cnt), 64'h6);
        for (int unsigned u = 0; u < N; u++) drive(u, 64'h220 + 64'(u), 3'(u), 8'h0);
        step();
        idle_all();
        #1;
        check("t4_rr_kept_p0", unit(0), 64'h2);
        check("t4_rr_kept_p1_res", res(1), 64'h223);
        step();
        check("t4_rr_next_p0_res", res(0), 64'h220);
        step();
        check("t4_drained", vld(), 64'h0);
        check("t4_cnt", 64'(conflict_cnt), 64'h7);

        // reset in the middle of traffic
        for (int unsigned c = 0; c < 3; c++) begin
            for (int unsigned u = 0; u < N; u++) drive(u, 64'h300 + 64'(u), 3'(u), 8'h0);
            step();
        end
        rst_i = 1'b1;
        #1;
        check("t5_rst_ready", rdy(), 64'h0);
        check("t5_rst_valid", vld(), 64'h0);
        step();
        rst_i = 1'b0;
        idle_all();
        #1;
        check("t5_ready", rdy(), 64'hF);
        check("t5_valid", vld(), 64'h0);
        check("t5_cnt", 64'(conflict_cnt), 64'h0);

        // no bypass: 0x55 appears one cycle after the push
        drive(0, 64'h55, 3'd1, 8'h0);
        #1;
        check("t6_same_cycle", vld(), 64'h0);
        step();
        idle_all();
        #1;
        check("t6_valid", vld(), 64'h1);
        check("t6_res", res(0), 64'h55);
        check("t6_unit", unit(0), 64'h0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
